// File: rtl/sdram_pkg.sv
// Shared constants and types for the two-requester SDRAM arbiter.
//   DATA_W / BE_W / ADDR_W : default Avalon-MM bus widths
//   req_id_t               : requester identifier (0 or 1), also the tag FIFO payload
//   arb_state_e            : arbiter FSM encoding
package sdram_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned BE_W   = 2;
  localparam int unsigned ADDR_W = 32;

  typedef logic req_id_t;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/sdram_rd_tag_fifo.sv
// Tag FIFO holding the requester ID of every accepted read, in issue order.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset (empties the FIFO)
//   push, din    : enqueue a tag (ignored while full)
//   pop          : dequeue the head tag (ignored while empty)
//   dout         : head tag
//   full, empty  : occupancy flags
module sdram_rd_tag_fifo
  import sdram_pkg::*;
#(
  parameter int unsigned MAX_PEND = 4
) (
  input  logic    clk,
  input  logic    reset_n,
  input  logic    push,
  input  logic    pop,
  input  req_id_t din,
  output req_id_t dout,
  output logic    full,
  output logic    empty
);

  localparam int unsigned PtrW = $clog2(MAX_PEND);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [PtrW:0] wr_ptr_q, rd_ptr_q;
  req_id_t       mem_q [MAX_PEND];
  logic          do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q[PtrW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + {{PtrW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr_q <= rd_ptr_q + {{PtrW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PtrW-1:0]] <= din;
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM SDRAM master port between two requesters.
// One accepted transfer per grant; read returns are steered back by a tag FIFO.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   rN_*  (N = 0, 1)      : requester-side Avalon-MM slave (cmd in, waitrequest/readdata out)
//   chipselect..writedata : command to the SDRAM controller
//   waitrequest, readdatavalid, readdata : SDRAM controller response
//   rd_orphan             : sticky, set when a beat returns with no read outstanding
module sdram_arbiter #(
  parameter int unsigned ADDR_W   = sdram_pkg::ADDR_W,
  parameter int unsigned DATA_W   = sdram_pkg::DATA_W,
  parameter int unsigned BE_W     = sdram_pkg::BE_W,
  parameter int unsigned MAX_PEND = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              r0_chipselect,
  input  logic              r0_read_n,
  input  logic              r0_write_n,
  input  logic [ADDR_W-1:0] r0_address,
  input  logic [BE_W-1:0]   r0_byteenable,
  input  logic [DATA_W-1:0] r0_writedata,
  output logic              r0_waitrequest,
  output logic              r0_readdatavalid,
  output logic [DATA_W-1:0] r0_readdata,
  input  logic              r1_chipselect,
  input  logic              r1_read_n,
  input  logic              r1_write_n,
  input  logic [ADDR_W-1:0] r1_address,
  input  logic [BE_W-1:0]   r1_byteenable,
  input  logic [DATA_W-1:0] r1_writedata,
  output logic              r1_waitrequest,
  output logic              r1_readdatavalid,
  output logic [DATA_W-1:0] r1_readdata,
  output logic              chipselect,
  output logic              read_n,
  output logic              write_n,
  output logic [ADDR_W-1:0] address,
  output logic [BE_W-1:0]   byteenable,
  output logic [DATA_W-1:0] writedata,
  input  logic              waitrequest,
  input  logic              readdatavalid,
  input  logic [DATA_W-1:0] readdata,
  output logic              rd_orphan
);

  import sdram_pkg::*;

  arb_state_e state_q, state_d;
  req_id_t    owner_q, owner_d;
  req_id_t    rr_ptr_q, rr_ptr_d;
  logic       orphan_q;

  logic [1:0]        req;
  logic              own_cs, own_read_n, own_write_n;
  logic [ADDR_W-1:0] own_address;
  logic [BE_W-1:0]   own_byteenable;
  logic [DATA_W-1:0] own_writedata;
  logic              own_req, own_is_rd, in_own, blocked, accept, own_wait;
  logic              fifo_full, fifo_empty, fifo_pop;
  req_id_t           tag_head;

  assign req[0] = r0_chipselect & (~r0_read_n | ~r0_write_n);
  assign req[1] = r1_chipselect & (~r1_read_n | ~r1_write_n);

  assign own_cs         = owner_q ? r1_chipselect : r0_chipselect;
  assign own_read_n     = owner_q ? r1_read_n     : r0_read_n;
  assign own_write_n    = owner_q ? r1_write_n    : r0_write_n;
  assign own_address    = owner_q ? r1_address    : r0_address;
  assign own_byteenable = owner_q ? r1_byteenable : r0_byteenable;
  assign own_writedata  = owner_q ? r1_writedata  : r0_writedata;

  assign in_own    = (state_q == OWN);
  assign own_req   = req[owner_q];
  // A write strobe wins over a simultaneous read strobe.
  assign own_is_rd = own_cs & ~own_read_n & own_write_n;
  // Stall a read that would overflow the tag FIFO.
  assign blocked   = in_own & own_is_rd & fifo_full;
  assign accept    = in_own & own_req & ~waitrequest & ~blocked;
  assign own_wait  = blocked | waitrequest;

  always_comb begin
    chipselect     = 1'b0;
    read_n         = 1'b1;
    write_n        = 1'b1;
    address        = '0;
    byteenable     = '0;
    writedata      = '0;
    r0_waitrequest = 1'b1;
    r1_waitrequest = 1'b1;
    if (in_own) begin
      chipselect = own_cs & ~blocked;
      read_n     = own_read_n | ~own_write_n | blocked;
      write_n    = own_write_n;
      address    = own_address;
      byteenable = own_byteenable;
      writedata  = own_writedata;
      if (owner_q) r1_waitrequest = own_wait;
      else         r0_waitrequest = own_wait;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = OWN;
          owner_d = req[rr_ptr_q] ? rr_ptr_q : ~rr_ptr_q;
        end
      end
      OWN: begin
        if (accept) begin
          rr_ptr_d = ~owner_q;
          if (req[~owner_q])     owner_d = ~owner_q;
          else if (!own_req)     state_d = IDLE;
        end else if (!own_req) begin
          // Request withdrawn before acceptance: give the port back.
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      rr_ptr_q <= 1'b0;
      orphan_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      orphan_q <= orphan_q | (readdatavalid & fifo_empty);
    end
  end

  assign fifo_pop = readdatavalid & ~fifo_empty;

  sdram_rd_tag_fifo #(
    .MAX_PEND (MAX_PEND)
  ) u_tag_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (accept & own_is_rd),
    .pop     (fifo_pop),
    .din     (owner_q),
    .dout    (tag_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign r0_readdatavalid = fifo_pop & (tag_head == 1'b0);
  assign r1_readdatavalid = fifo_pop & (tag_head == 1'b1);
  assign r0_readdata      = readdata;
  assign r1_readdata      = readdata;
  assign rd_orphan        = orphan_q;

endmodule
